// File: rtl/xor_parity_accum.sv
// ---------------------------------------------------------------------------
// xor_parity_accum
//
// Folds a framed stream of WIDTH-bit words into a running bitwise XOR
// checksum and reports, once per frame, the checksum, its parity bit, the
// number of words accepted (saturating at MAX_WORDS) and an overflow flag.
// Frames end on the word that carries in_last. Both sides use valid/ready
// handshakes. While a result is pending the input side is stalled.
//
// Parameters
//   WIDTH       data word width in bits (>= 1)
//   MAX_WORDS   largest word count reported per frame (>= 1)
//   ODD_PARITY  0: out_parity = ^out_xor, 1: out_parity = ~^out_xor
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid      upstream word valid
//   in_ready      block can accept a word (high in IDLE/ACCUM)
//   in_data       data word
//   in_last       marks the final word of a frame
//   out_valid     frame result valid (high in DONE)
//   out_ready     downstream accepts the result
//   out_xor       XOR of all words of the frame
//   out_parity    parity of out_xor, polarity set by ODD_PARITY
//   out_count     words accepted, saturating at MAX_WORDS
//   out_overflow  frame carried more than MAX_WORDS words
// ---------------------------------------------------------------------------
module xor_parity_accum #(
   parameter int WIDTH      = 8,
   parameter int MAX_WORDS  = 16,
   parameter int ODD_PARITY = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [WIDTH-1:0]                   in_data,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WIDTH-1:0]                   out_xor,
   output logic                               out_parity,
   output logic [$clog2(MAX_WORDS+1)-1:0]     out_count,
   output logic                               out_overflow
);

   localparam int   CW      = $clog2(MAX_WORDS + 1);
   localparam logic ODD_BIT = (ODD_PARITY != 0);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             ovf;

   logic             xfer;
   logic [WIDTH-1:0] acc_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             ovf_nxt;

   // Word count never wraps: it sticks at MAX_WORDS once reached.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == CW'(MAX_WORDS)) ? c : c + CW'(1);
   endfunction

   function automatic logic parity_of(input logic [WIDTH-1:0] x);
      return (^x) ^ ODD_BIT;
   endfunction

   // in_ready is low in DONE, so xfer can only be true in IDLE/ACCUM.
   // Gating every state update on xfer keeps undriven in_data/in_last
   // out of the registers while in_valid is low.
   assign xfer = in_valid && in_ready;

   // Values the frame registers take on an accepted word. The first word
   // of a frame (IDLE) restarts the checksum instead of folding into it.
   always_comb begin
      acc_nxt = acc ^ in_data;
      cnt_nxt = sat_inc(cnt);
      ovf_nxt = ovf | (cnt == CW'(MAX_WORDS));
      if (state == IDLE) begin
         acc_nxt = in_data;
         cnt_nxt = CW'(1);
         ovf_nxt = 1'b0;
      end
   end

   // Result registers are loaded on the edge that accepts the last word, so
   // they are valid together with out_valid and then hold until the next
   // frame completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         acc          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         out_xor      <= '0;
         out_parity   <= ODD_BIT;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (xfer) begin
                  acc <= acc_nxt;
                  cnt <= cnt_nxt;
                  ovf <= ovf_nxt;
                  if (in_last) begin
                     state        <= DONE;
                     in_ready     <= 1'b0;
                     out_valid    <= 1'b1;
                     out_xor      <= acc_nxt;
                     out_parity   <= parity_of(acc_nxt);
                     out_count    <= cnt_nxt;
                     out_overflow <= ovf_nxt;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DONE: begin
               // No same-cycle accept: in_ready rises after the handshake.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xor_parity_accum.sv
// ---------------------------------------------------------------------------
// tb_xor_parity_accum
//
// Drives three instances of xor_parity_accum from one shared stimulus
// stream: default parameters, MAX_WORDS=4, and ODD_PARITY=1. Each frame is
// kept as a list of words and the expected result for every instance is
// computed from that list.
// ---------------------------------------------------------------------------
module tb_xor_parity_accum;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_ready;

   logic       d0_in_ready, d0_out_valid, d0_parity, d0_ovf;
   logic [7:0] d0_xor;
   logic [4:0] d0_count;
   logic       d1_in_ready, d1_out_valid, d1_parity, d1_ovf;
   logic [7:0] d1_xor;
   logic [2:0] d1_count;
   logic       d2_in_ready, d2_out_valid, d2_parity, d2_ovf;
   logic [7:0] d2_xor;
   logic [4:0] d2_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] frm[$];

   always #5 clk = ~clk;

   xor_parity_accum u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(d0_out_valid),
      .out_ready(out_ready), .out_xor(d0_xor), .out_parity(d0_parity),
      .out_count(d0_count), .out_overflow(d0_ovf)
   );

   xor_parity_accum #(.WIDTH(8), .MAX_WORDS(4), .ODD_PARITY(0)) u_ovf (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(d1_out_valid),
      .out_ready(out_ready), .out_xor(d1_xor), .out_parity(d1_parity),
      .out_count(d1_count), .out_overflow(d1_ovf)
   );

   xor_parity_accum #(.WIDTH(8), .MAX_WORDS(16), .ODD_PARITY(1)) u_odd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(d2_out_valid),
      .out_ready(out_ready), .out_xor(d2_xor), .out_parity(d2_parity),
      .out_count(d2_count), .out_overflow(d2_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected result of the current frame for a given configuration.
   task automatic model(input int maxw, input bit odd,
                        output logic [7:0] x, output int c, output bit o, output bit p);
      x = 8'h00;
      foreach (frm[i]) x = x ^ frm[i];
      c = (frm.size() > maxw) ? maxw : frm.size();
      o = (frm.size() > maxw);
      p = (^x) ^ odd;
   endtask

   task automatic check_res(input string tag, input int maxw, input bit odd, input bit exp_vld,
                            input logic [31:0] vld, input logic [31:0] rdy,
                            input logic [31:0] x, input logic [31:0] c,
                            input logic [31:0] o, input logic [31:0] p);
      logic [7:0] ex;
      int         ec;
      bit         eo, ep;
      model(maxw, odd, ex, ec, eo, ep);
      chk({tag, "_valid"}, vld, 32'(exp_vld));
      chk({tag, "_in_ready"}, rdy, 32'(!exp_vld));
      chk({tag, "_xor"}, x, 32'(ex));
      chk({tag, "_count"}, c, 32'(ec));
      chk({tag, "_overflow"}, o, 32'(eo));
      chk({tag, "_parity"}, p, 32'(ep));
   endtask

   task automatic check_all(input string tag, input bit exp_vld);
      check_res({tag, "_d0"}, 16, 1'b0, exp_vld, 32'(d0_out_valid), 32'(d0_in_ready),
                32'(d0_xor), 32'(d0_count), 32'(d0_ovf), 32'(d0_parity));
      check_res({tag, "_d1"}, 4, 1'b0, exp_vld, 32'(d1_out_valid), 32'(d1_in_ready),
                32'(d1_xor), 32'(d1_count), 32'(d1_ovf), 32'(d1_parity));
      check_res({tag, "_d2"}, 16, 1'b1, exp_vld, 32'(d2_out_valid), 32'(d2_in_ready),
                32'(d2_xor), 32'(d2_count), 32'(d2_ovf), 32'(d2_parity));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_d0_in_ready"}, 32'(d0_in_ready), 32'd1);
      chk({tag, "_d0_valid"}, 32'(d0_out_valid), 32'd0);
      chk({tag, "_d0_xor"}, 32'(d0_xor), 32'd0);
      chk({tag, "_d0_parity"}, 32'(d0_parity), 32'd0);
      chk({tag, "_d0_count"}, 32'(d0_count), 32'd0);
      chk({tag, "_d0_overflow"}, 32'(d0_ovf), 32'd0);
      chk({tag, "_d1_valid"}, 32'(d1_out_valid), 32'd0);
      chk({tag, "_d1_count"}, 32'(d1_count), 32'd0);
      chk({tag, "_d2_in_ready"}, 32'(d2_in_ready), 32'd1);
      chk({tag, "_d2_valid"}, 32'(d2_out_valid), 32'd0);
      chk({tag, "_d2_xor"}, 32'(d2_xor), 32'd0);
      chk({tag, "_d2_parity"}, 32'(d2_parity), 32'd1);
   endtask

   // Present the words of frm, last flag on the final one, optionally with
   // idle gaps carrying garbage on in_data/in_last.
   task automatic send_words(input bit gaps, input bit mark_last);
      for (int i = 0; i < frm.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
               step();
            end
         end
         in_valid = 1'b1;
         in_data  = frm[i];
         in_last  = mark_last && (i == frm.size() - 1);
         chk("accept_in_ready", 32'(d0_in_ready), 32'd1);
         step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // Check the pending result, stall it for bp cycles with words offered
   // at the input, then complete the handshake.
   task automatic finish_frame(input string tag, input int bp);
      check_all({tag, "_done"}, 1'b1);
      repeat (bp) begin
         in_valid  = 1'b1;
         in_data   = 8'($urandom);
         in_last   = 1'($urandom);
         out_ready = 1'b0;
         step();
         check_all({tag, "_stall"}, 1'b1);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_all({tag, "_hold"}, 1'b0);
   endtask

   task automatic run_frame(input string tag, input int bp, input bit gaps);
      send_words(gaps, 1'b1);
      finish_frame(tag, bp);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_reset("reset");

      // Basic frame
      frm = '{8'hA5, 8'h3C, 8'hFF};
      run_frame("basic", 0, 1'b0);
      chk("basic_xor_lit", 32'(d0_xor), 32'h66);
      chk("basic_parity_lit", 32'(d0_parity), 32'd0);
      chk("basic_count_lit", 32'(d0_count), 32'd3);
      chk("odd_parity_lit", 32'(d2_parity), 32'd1);

      // Single-word frame with a short stall
      frm = '{8'h01};
      run_frame("single", 2, 1'b0);
      chk("single_xor_lit", 32'(d0_xor), 32'h01);
      chk("single_parity_lit", 32'(d0_parity), 32'd1);
      chk("single_count_lit", 32'(d0_count), 32'd1);

      // Overflow on the MAX_WORDS=4 instance
      frm = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
      run_frame("ovf", 0, 1'b0);
      chk("ovf_xor_lit", 32'(d1_xor), 32'h00);
      chk("ovf_count_lit", 32'(d1_count), 32'd4);
      chk("ovf_flag_lit", 32'(d1_ovf), 32'd1);
      chk("ovf_parity_lit", 32'(d1_parity), 32'd0);
      chk("noovf_count_lit", 32'(d0_count), 32'd6);

      // Backpressure with words offered during DONE
      frm = '{8'h0F};
      run_frame("bp", 5, 1'b0);
      chk("bp_xor_lit", 32'(d0_xor), 32'h0F);

      // Reset mid-frame discards the partial frame
      frm = '{8'h12, 8'h34};
      send_words(1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset("rst_mid");
      frm = '{8'h0F};
      run_frame("after_rst", 0, 1'b0);
      chk("after_rst_xor_lit", 32'(d0_xor), 32'h0F);
      chk("after_rst_count_lit", 32'(d0_count), 32'd1);

      // Reset while a result is pending drops it
      frm = '{8'h55, 8'h0A};
      send_words(1'b0, 1'b1);
      check_all("pend_done", 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset("rst_done");

      // Random frames, gaps and stalls
      for (int f = 0; f < 40; f++) begin
         int n;
         frm.delete();
         n = $urandom_range(1, 20);
         for (int k = 0; k < n; k++) frm.push_back(8'($urandom));
         run_frame("rand", $urandom_range(0, 3), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xor_parity_accum.md
Name: xor_parity_accum

Overview:
- Parametrised successor to the team's single-bit CMOS XOR cell.
- Folds a stream of WIDTH-bit words into a running bitwise XOR checksum. Also produces a parity bit that is even or odd depending on a parameter.
- Frames are delimited by in_last. Upstream and downstream use valid/ready handshakes.
- Sits between a word source and a link/check stage. It is the checksum engine for frame integrity.

Parameters:
- WIDTH, 8: data word width in bits; must be >= 1.
- MAX_WORDS, 16: maximum words per frame that are counted; must be >= 1.
- ODD_PARITY, 0: 0 gives even parity (out_parity = XOR-reduce of checksum); 1 gives odd parity (inverted).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  data word.
- in_last  input  1  qualifies the final word of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts result.
- out_xor  output  WIDTH  bitwise XOR of all frame words.
- out_parity  output  1  parity of out_xor per ODD_PARITY.
- out_count  output  CW = clog2(MAX_WORDS+1)  words accepted, saturating at MAX_WORDS.
- out_overflow  output  1  frame exceeded MAX_WORDS words.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_xor=0, out_parity=ODD_PARITY, out_count=0, out_overflow=0.
- Transfer: a word transfers when in_valid && in_ready on a rising edge. A result transfers when out_valid && out_ready.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On transfer: acc <= in_data, cnt <= 1, ovf <= 0.
  - Next state is DONE if in_last, else ACCUM.
  - in_last outside a transfer is ignored.
- ACCUM:
  - in_ready=1.
  - On transfer: acc <= acc ^ in_data.
  - If cnt == MAX_WORDS: cnt holds and ovf <= 1. Otherwise cnt <= cnt + 1.
  - The word is always folded into acc, even on overflow.
  - Next state is DONE if in_last.
  - With no transfer, all state holds.
- DONE:
  - in_ready=0. in_valid is ignored and no word is consumed.
  - out_valid=1; out_xor, out_count and out_overflow present the registered acc, cnt and ovf.
  - out_parity = (^acc) ^ ODD_PARITY.
  - Outputs are stable while out_valid && !out_ready.
  - On result transfer the next state is IDLE. in_ready rises the following cycle; there is no same-cycle accept.
- Latency: last word accepted at edge t, so out_valid=1 in the cycle after edge t. Minimum frame turnaround is 2 cycles for a 1-word frame plus handshake.
- Throughput: 1 word/cycle while in IDLE/ACCUM.
- Output holding: outside DONE, out_valid=0 and the out_* data outputs hold their last presented values. They are only 0 after reset.
- Arithmetic: XOR only, with no carries. out_count is unsigned and saturates, never wraps.
- Reset mid-operation: rst overrides every other input in the same cycle. A partial frame is discarded and no result is produced. A pending DONE result is dropped.
- in_data/in_last may be X when in_valid=0. The block must not propagate X into state in that case.

Test Plan:
- Basic frame (defaults): words 0xA5, 0x3C, 0xFF with last on 0xFF, out_ready=1 → one out_valid pulse the cycle after the 3rd accept, with out_xor=0x66, out_parity=0, out_count=3, out_overflow=0.
- Single-word frame: 0x01 with in_last → out_xor=0x01, out_parity=1, out_count=1. in_ready is 0 during DONE and returns to 1 the cycle after the handshake.
- Overflow (MAX_WORDS=4): six words of 0x01, last on the 6th → out_xor=0x00, out_count=4, out_overflow=1, out_parity=0.
- Backpressure: finish frame {0x0F}, hold out_ready=0 for 5 cycles while driving in_valid=1 with 0xAA → out_valid stays 1, out_xor stays 0x0F, in_ready stays 0, and 0xAA is never folded in. Then raise out_ready → IDLE.
- Reset mid-frame: accept 0x12, 0x34 (no last), assert rst for 1 cycle → all outputs at reset values. Next frame {0x0F last} → out_xor=0x0F, out_count=1.
- Odd parity (ODD_PARITY=1): frame {0xA5, 0x3C, 0xFF last} → out_xor=0x66, out_parity=1. After reset, out_parity=1.
